// File: rtl/ts_record_serializer_pkg.sv
// Shared types and constants for the timestamp record stream.
// The timestamper produces ts_record_t; the serializer frames it into bytes.
package ts_stream_pkg;

    localparam logic [7:0] MAGIC_BYTE = 8'hA5;

    // Widest record the block family supports.
    localparam int unsigned ID_W_MAX = 8;
    localparam int unsigned TS_W_MAX = 64;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [TS_W_MAX-1:0] start_ts;
        logic [TS_W_MAX-1:0] end_ts;
        logic [TS_W_MAX-1:0] delta;
    } ts_record_t;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } ser_state_e;

    // Magic, id, two sequence bytes, then three timestamps.
    function automatic int unsigned rec_bytes(input int unsigned ts_w);
        return 4 + 3 * (ts_w / 8);
    endfunction

endpackage

// File: rtl/ts_record_serializer_if.sv
// Record input handshake plus 8-bit valid/ready/last byte stream.
// slave = serializer view, master = upstream/downstream environment view.
interface ts_record_serializer_if #(
    parameter int unsigned ID_W = 4,
    parameter int unsigned TS_W = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [ID_W-1:0] in_id;
    logic [TS_W-1:0] in_start_ts;
    logic [TS_W-1:0] in_end_ts;
    logic [TS_W-1:0] in_ts;

    logic            m_tvalid;
    logic            m_tready;
    logic [7:0]      m_tdata;
    logic            m_tlast;

    modport slave (
        input  in_valid, in_id, in_start_ts, in_end_ts, in_ts, m_tready,
        output in_ready, m_tvalid, m_tdata, m_tlast
    );

    modport master (
        output in_valid, in_id, in_start_ts, in_end_ts, in_ts, m_tready,
        input  in_ready, m_tvalid, m_tdata, m_tlast
    );

endinterface

// File: rtl/ts_record_serializer.sv
// Packs timestamper records into fixed-length big-endian byte frames
// (magic, id, sequence, start, end, delta) on a valid/ready/last stream.
module ts_record_serializer
    import ts_stream_pkg::*;
#(
    parameter int unsigned ID_W  = 4,
    parameter int unsigned TS_W  = 64,
    parameter int unsigned SEQ_W = 16,
    parameter logic [7:0]  MAGIC = MAGIC_BYTE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ts_record_serializer_if.slave bus,
    output logic [31:0]           frame_count,
    output logic                  busy
);

    localparam int unsigned REC_BYTES = rec_bytes(TS_W);
    localparam int unsigned FRAME_W   = REC_BYTES * 8;
    localparam int unsigned IDX_W     = $clog2(REC_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

    ser_state_e           state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [FRAME_W-1:0]   frame_q;
    logic [SEQ_W-1:0]     seq_q;
    logic [31:0]          frame_cnt_q;
    logic                 m_tvalid_q;
    logic                 m_tlast_q;

    ts_record_t           rec;
    logic [FRAME_W-1:0]   frame_d;
    logic                 byte_fire;
    logic                 last_fire;
    logic                 in_ready_c;
    logic                 in_fire;

    // Normalise the incoming record to the shared struct.
    always_comb begin
        rec          = '0;
        rec.id       = 8'(bus.in_id);
        rec.start_ts = 64'(bus.in_start_ts);
        rec.end_ts   = 64'(bus.in_end_ts);
        rec.delta    = 64'(bus.in_ts);
    end

    assign frame_d = {MAGIC, rec.id, seq_q,
                      rec.start_ts[TS_W-1:0],
                      rec.end_ts[TS_W-1:0],
                      rec.delta[TS_W-1:0]};

    assign byte_fire  = m_tvalid_q && bus.m_tready;
    assign last_fire  = byte_fire && m_tlast_q;
    // Accepting on the last byte keeps consecutive frames bubble-free.
    assign in_ready_c = (state_q == S_IDLE) || last_fire;
    assign in_fire    = bus.in_valid && in_ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            frame_q     <= '0;
            seq_q       <= '0;
            frame_cnt_q <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
        end else begin
            if (last_fire) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end

            if (in_fire) begin
                state_q    <= S_SEND;
                idx_q      <= '0;
                frame_q    <= frame_d;
                seq_q      <= seq_q + SEQ_W'(1);
                m_tvalid_q <= 1'b1;
                m_tlast_q  <= 1'b0;
            end else if (byte_fire) begin
                if (m_tlast_q) begin
                    state_q    <= S_IDLE;
                    idx_q      <= '0;
                    frame_q    <= '0;
                    m_tvalid_q <= 1'b0;
                    m_tlast_q  <= 1'b0;
                end else begin
                    // Top byte of frame_q is always the byte on the bus.
                    idx_q     <= idx_q + IDX_W'(1);
                    frame_q   <= {frame_q[FRAME_W-9:0], 8'h00};
                    m_tlast_q <= ((idx_q + IDX_W'(1)) == LAST_IDX);
                end
            end
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.m_tvalid = m_tvalid_q;
    assign bus.m_tdata  = frame_q[FRAME_W-1 -: 8];
    assign bus.m_tlast  = m_tlast_q;
    assign frame_count  = frame_cnt_q;
    assign busy         = (state_q == S_SEND);

endmodule

// File: tb/tb_ts_record_serializer.sv
// Directed bench for ts_record_serializer: vector table plus hand-written
// stall, back-to-back, sequence-wrap, random-ready and mid-frame reset cases.
module tb_ts_record_serializer;

    localparam int unsigned NB = 28;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] frame_count;
    logic        busy;

    ts_record_serializer_if #(.ID_W(4), .TS_W(64)) bus();

    ts_record_serializer #(
        .ID_W(4), .TS_W(64), .SEQ_W(16), .MAGIC(8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .frame_count (frame_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mon_idx = 0;
    int mon_done = 0;
    logic [223:0] exp_q[$];
    logic [7:0]   got_b[$];
    int           got_cyc[$];
    logic [223:0] mon_f;
    logic         stall_v = 1'b0;
    logic [7:0]   stall_d = 8'h00;
    logic         stall_l = 1'b0;
    int           rdy_mode = 0;
    logic         rdy_force = 1'b1;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] st;
        logic [63:0] en;
        logic [63:0] dl;
        logic [15:0] sq;
        logic [31:0] fc;
    } vec_t;

    vec_t vt[4];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [223:0] mk(input logic [3:0] id, input logic [63:0] st,
                                        input logic [63:0] en, input logic [63:0] dl,
                                        input logic [15:0] sq);
        return {8'hA5, 4'h0, id, sq, st, en, dl};
    endfunction

    always @(posedge clk) cyc++;

    initial bus.m_tready = 1'b1;
    always @(posedge clk) begin
        #2;
        if (rdy_mode == 1) bus.m_tready = 1'($urandom_range(0, 1));
        else               bus.m_tready = rdy_force;
    end

    // Byte monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_idx = 0;
            exp_q.delete();
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                chk("stall_valid", 64'(bus.m_tvalid), 64'd1);
                chk("stall_data", 64'(bus.m_tdata), 64'(stall_d));
                chk("stall_last", 64'(bus.m_tlast), 64'(stall_l));
            end
            stall_v = bus.m_tvalid && !bus.m_tready;
            stall_d = bus.m_tdata;
            stall_l = bus.m_tlast;
            if (!bus.m_tvalid) chk("idle_data", 64'(bus.m_tdata), 64'd0);
            if (busy && !(bus.m_tvalid && bus.m_tready && bus.m_tlast))
                chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
            if (bus.m_tvalid && bus.m_tready) begin
                got_b.push_back(bus.m_tdata);
                got_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h expected no byte", bus.m_tdata);
                end else begin
                    mon_f = exp_q[0];
                    chk($sformatf("frame_byte[%0d]", mon_idx), 64'(bus.m_tdata),
                        64'(mon_f[223 - 8*mon_idx -: 8]));
                    chk($sformatf("tlast[%0d]", mon_idx), 64'(bus.m_tlast),
                        64'(mon_idx == NB - 1));
                    if (mon_idx == NB - 1) begin
                        mon_idx = 0;
                        void'(exp_q.pop_front());
                        mon_done++;
                    end else begin
                        mon_idx++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] id, input logic [63:0] st, input logic [63:0] en,
                        input logic [63:0] dl, input logic [15:0] sq);
        bit fired = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_id       = id;
        bus.in_start_ts = st;
        bus.in_end_ts   = en;
        bus.in_ts       = dl;
        exp_q.push_back(mk(id, st, en, dl, sq));
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                fired = 1'b1;
                break;
            end
        end
        if (!fired) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 3000 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        bus.in_valid    = 1'b0;
        bus.in_id       = 4'($urandom);
        bus.in_start_ts = {$urandom, $urandom};
        bus.in_end_ts   = {$urandom, $urandom};
        bus.in_ts       = {$urandom, $urandom};
    endtask

    task automatic drain(input int lim);
        bit ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got busy %0b pending %0d expected idle", busy, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input int n);
        bit ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            #1;
            if (got_b.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL byte_wait: got %0d bytes expected %0d", got_b.size(), n);
        end
    endtask

    initial begin
        logic [7:0]  hand[NB];
        logic [15:0] nxt_seq;
        logic [31:0] exp_fc;
        int          done0;

        vt[0] = '{4'h1, 64'h0102030405060708, 64'h1112131415161718, 64'h1010101010101010, 16'd1, 32'd2};
        vt[1] = '{4'hF, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 64'h0000000000000001, 16'd2, 32'd3};
        vt[2] = '{4'h0, 64'h8000000000000001, 64'h80000000000000FF, 64'h00000000000000FE, 16'd3, 32'd4};
        vt[3] = '{4'hA, 64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF10D, 64'h0000000000000100, 16'd4, 32'd5};

        for (int i = 0; i < NB; i++) hand[i] = 8'h00;
        hand[0]  = 8'hA5;
        hand[1]  = 8'h03;
        hand[11] = 8'h10;
        hand[19] = 8'h25;
        hand[27] = 8'h15;

        scramble();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
        chk("rst_m_tdata", 64'(bus.m_tdata), 64'd0);
        chk("rst_m_tlast", 64'(bus.m_tlast), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);

        // Single record with hand-listed bytes and first-byte latency.
        @(posedge clk);
        #1;
        got_b.delete();
        got_cyc.delete();
        send(4'h3, 64'h10, 64'h25, 64'h15, 16'h0000);
        scramble();
        @(negedge clk);
        chk("latency_valid", 64'(bus.m_tvalid), 64'd1);
        chk("latency_byte0", 64'(bus.m_tdata), 64'hA5);
        drain(200);
        chk("t1_len", 64'(got_b.size()), 64'(NB));
        for (int i = 0; i < NB && i < got_b.size(); i++)
            chk($sformatf("t1_byte[%0d]", i), 64'(got_b[i]), 64'(hand[i]));
        chk("t1_frame_count", 64'(frame_count), 64'd1);

        // Vector table.
        for (int v = 0; v < 4; v++) begin
            send(vt[v].id, vt[v].st, vt[v].en, vt[v].dl, vt[v].sq);
            scramble();
            drain(200);
            chk($sformatf("vec%0d_frame_count", v), 64'(frame_count), 64'(vt[v].fc));
        end

        // Downstream stall at byte 10.
        got_b.delete();
        send(4'h5, 64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h0123456789ABCDEF, 16'd5);
        scramble();
        wait_bytes(10);
        rdy_force = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall_count", 64'(got_b.size()), 64'd10);
        repeat (3) @(posedge clk);
        #1 rdy_force = 1'b1;
        drain(200);
        chk("stall_len", 64'(got_b.size()), 64'(NB));
        chk("stall_frame_count", 64'(frame_count), 64'd6);

        // Back-to-back records: no bubble between frames.
        got_b.delete();
        got_cyc.delete();
        send(4'h6, 64'h1, 64'h2, 64'h1, 16'd6);
        send(4'h7, 64'h3, 64'h9, 64'h6, 16'd7);
        scramble();
        drain(200);
        chk("b2b_len", 64'(got_b.size()), 64'(2 * NB));
        if (got_b.size() >= 2 * NB) begin
            chk("b2b_gap", 64'(got_cyc[NB] - got_cyc[NB-1]), 64'd1);
            chk("b2b_magic", 64'(got_b[NB]), 64'hA5);
            chk("b2b_seq_lo", 64'(got_b[NB+3]), 64'h07);
        end
        chk("b2b_frame_count", 64'(frame_count), 64'd8);

        // Sequence wrap from FFFF to 0000.
        @(negedge clk);
        force dut.seq_q = 16'hFFFF;
        @(negedge clk);
        release dut.seq_q;
        @(posedge clk);
        #1;
        got_b.delete();
        send(4'h2, 64'hAA, 64'hBB, 64'h11, 16'hFFFF);
        send(4'h4, 64'hCC, 64'hDD, 64'h11, 16'h0000);
        scramble();
        drain(200);
        if (got_b.size() >= 2 * NB) begin
            chk("wrap_seq_hi_a", 64'(got_b[2]), 64'hFF);
            chk("wrap_seq_hi_b", 64'(got_b[NB+2]), 64'h00);
            chk("wrap_seq_lo_b", 64'(got_b[NB+3]), 64'h00);
        end else begin
            chk("wrap_len", 64'(got_b.size()), 64'(2 * NB));
        end
        chk("wrap_frame_count", 64'(frame_count), 64'd10);

        // Random ready with random records and idle gaps.
        rdy_mode = 1;
        nxt_seq = 16'd1;
        exp_fc = 32'd10;
        done0 = mon_done;
        for (int i = 0; i < 100; i++) begin
            send(4'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, nxt_seq);
            nxt_seq = nxt_seq + 16'd1;
            exp_fc = exp_fc + 32'd1;
            if ($urandom_range(0, 3) == 0) begin
                scramble();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        scramble();
        drain(5000);
        rdy_mode = 0;
        chk("rand_frames", 64'(mon_done - done0), 64'd100);
        chk("rand_frame_count", 64'(frame_count), 64'(exp_fc));

        // Reset in the middle of a frame.
        @(posedge clk);
        #1;
        got_b.delete();
        send(4'h9, 64'h55, 64'h66, 64'h11, nxt_seq);
        scramble();
        wait_bytes(15);
        @(posedge clk);
        #1;
        chk("pre_reset_valid", 64'(bus.m_tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
        chk("mid_rst_m_tlast", 64'(bus.m_tlast), 64'd0);
        chk("mid_rst_m_tdata", 64'(bus.m_tdata), 64'd0);
        chk("mid_rst_frame_count", 64'(frame_count), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        got_b.delete();
        send(4'hC, 64'h100, 64'h180, 64'h80, 16'h0000);
        scramble();
        drain(200);
        chk("post_rst_len", 64'(got_b.size()), 64'(NB));
        if (got_b.size() >= 4) begin
            chk("post_rst_seq_hi", 64'(got_b[2]), 64'h00);
            chk("post_rst_seq_lo", 64'(got_b[3]), 64'h00);
        end
        chk("post_rst_frame_count", 64'(frame_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
